// File: rtl/note_display_ctrl_if.sv
// note_display_ctrl_if: note-event handshake from the decoder plus the glyph-drawer control bundle.
interface note_display_ctrl_if;
  logic       i_valid;
  logic [3:0] i_note;
  logic [1:0] i_octave;
  logic       o_ready;
  logic       i_wipe;
  logic [3:0] o_note;
  logic [1:0] o_octave;
  logic [7:0] o_x;
  logic [6:0] o_y;
  logic       o_ld_note;
  logic       o_clear;
  logic       o_busy;
  modport master (
    output i_valid, i_note, i_octave, i_wipe,
    input  o_ready, o_note, o_octave, o_x, o_y, o_ld_note, o_clear, o_busy
  );
  modport slave (
    input  i_valid, i_note, i_octave, i_wipe,
    output o_ready, o_note, o_octave, o_x, o_y, o_ld_note, o_clear, o_busy
  );
endinterface

// File: rtl/note_display_ctrl.sv
// note_display_ctrl: queues note events and sequences one glyph draw per event onto a fixed grid, with screen clears.
module note_display_ctrl #(
  parameter int COLS         = 4,
  parameter int ROWS         = 7,
  parameter int X0           = 2,
  parameter int Y0           = 2,
  parameter int COL_PITCH    = 40,
  parameter int ROW_PITCH    = 16,
  parameter int DRAW_CYCLES  = 480,
  parameter int CLEAR_CYCLES = 19600
) (
  input logic               clk,
  input logic               reset,
  note_display_ctrl_if.slave bus
);
  localparam int CW  = $clog2((CLEAR_CYCLES > DRAW_CYCLES ? CLEAR_CYCLES : DRAW_CYCLES) + 1);
  localparam int CBW = $clog2(COLS + 1);
  localparam int RBW = $clog2(ROWS + 1);

  typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_LOAD, S_DRAW, S_ADV} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [CBW-1:0]  r_col, w_col;
  logic [RBW-1:0]  r_row, w_row;
  logic [5:0]      r_fifo [4];
  logic [1:0]      r_wr, r_rd;
  logic [2:0]      r_count;
  logic            r_wipe_pend;
  logic [3:0]      r_note;
  logic [1:0]      r_octave;
  logic [7:0]      r_x;
  logic [6:0]      r_y;
  logic            r_ld_note, r_clear;
  logic            w_pop, w_push, w_ready, w_load, w_head_ok, w_last_col, w_last_row;
  logic [5:0]      w_head;
  logic [7:0]      w_x;
  logic [6:0]      w_y;

  assign w_ready    = r_count != 3'd4;
  assign w_push     = bus.i_valid && w_ready;
  assign w_head     = r_fifo[r_rd];
  assign w_head_ok  = (w_head[5:2] != 4'd0) && (w_head[5:2] <= 4'd12);
  assign w_last_col = r_col == CBW'(COLS - 1);
  assign w_last_row = r_row == RBW'(ROWS - 1);
  assign w_load     = (r_state == S_IDLE) && (w_next == S_LOAD);
  assign w_x        = 8'(X0 + COL_PITCH * int'(r_col));
  assign w_y        = 7'(Y0 + ROW_PITCH * int'(r_row));

  always_comb begin
    w_next = r_state;
    w_cnt  = '0;
    w_col  = r_col;
    w_row  = r_row;
    w_pop  = 1'b0;
    unique case (r_state)
      S_CLEAR: begin
        w_next = (r_cnt == CW'(CLEAR_CYCLES - 1)) ? S_IDLE : S_CLEAR;
        w_cnt  = (w_next == S_CLEAR) ? r_cnt + 1'b1 : '0;
        w_col  = (w_next == S_IDLE) ? '0 : r_col;
        w_row  = (w_next == S_IDLE) ? '0 : r_row;
      end
      S_IDLE: begin
        // a pending wipe outranks queued notes; bad note codes are popped and dropped
        w_pop  = !r_wipe_pend && (r_count != 3'd0);
        w_next = r_wipe_pend ? S_CLEAR : (w_pop && w_head_ok) ? S_LOAD : S_IDLE;
      end
      S_LOAD: w_next = S_DRAW;
      S_DRAW: begin
        w_next = (r_cnt == CW'(DRAW_CYCLES - 1)) ? S_ADV : S_DRAW;
        w_cnt  = (w_next == S_DRAW) ? r_cnt + 1'b1 : '0;
      end
      S_ADV: begin
        w_col  = w_last_col ? '0 : r_col + 1'b1;
        w_row  = w_last_col ? (w_last_row ? '0 : r_row + 1'b1) : r_row;
        w_next = (w_last_col && w_last_row) ? S_CLEAR : S_IDLE;
      end
      default: w_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_CLEAR;
      r_cnt       <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_wipe_pend <= 1'b0;
      r_note      <= '0;
      r_octave    <= '0;
      r_x         <= 8'(X0);
      r_y         <= 7'(Y0);
      r_ld_note   <= 1'b0;
      r_clear     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt;
      r_col       <= w_col;
      r_row       <= w_row;
      r_wr        <= r_wr + {1'b0, w_push};
      r_rd        <= r_rd + {1'b0, w_pop};
      r_count     <= r_count + {2'b0, w_push} - {2'b0, w_pop};
      r_wipe_pend <= bus.i_wipe ? 1'b1 : (w_next == S_CLEAR && r_state != S_CLEAR) ? 1'b0 : r_wipe_pend;
      r_note      <= w_load ? w_head[5:2] : r_note;
      r_octave    <= w_load ? w_head[1:0] : r_octave;
      r_x         <= w_load ? w_x : r_x;
      r_y         <= w_load ? w_y : r_y;
      r_ld_note   <= w_next == S_DRAW;
      r_clear     <= w_next != S_CLEAR;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr] <= {bus.i_note, bus.i_octave};
  end

  assign bus.o_ready   = w_ready;
  assign bus.o_busy    = r_state != S_IDLE;
  assign bus.o_note    = r_note;
  assign bus.o_octave  = r_octave;
  assign bus.o_x       = r_x;
  assign bus.o_y       = r_y;
  assign bus.o_ld_note = r_ld_note;
  assign bus.o_clear   = r_clear;
endmodule

// File: tb/tb_note_display_ctrl.sv
// tb_note_display_ctrl: directed scenarios for the note grid sequencer at its default timing.
module tb_note_display_ctrl;
  logic clk, reset;
  int checks, failures;
  note_display_ctrl_if bus();
  note_display_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  logic [3:0] five_n [5] = '{4'd1, 4'd2, 4'd7, 4'd11, 4'd12};
  logic [1:0] five_o [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic int ex_x(input int s); return 2 + 40 * (s % 4); endfunction
  function automatic int ex_y(input int s); return 2 + 16 * (s / 4); endfunction

  // observes one draw: waits for ld_note, captures the glyph fields, counts high cycles
  task automatic wait_draw(input int budget, output bit seen, output int waited, output logic [3:0] n,
                           output logic [1:0] o, output logic [7:0] xx, output logic [6:0] yy,
                           output int len, output bit stable);
    waited = 0; len = 0; stable = 1'b1;
    while (!bus.o_ld_note && waited < budget) begin @(negedge clk); waited++; end
    seen = bus.o_ld_note; n = bus.o_note; o = bus.o_octave; xx = bus.o_x; yy = bus.o_y;
    while (bus.o_ld_note && len < 2000) begin
      if ({bus.o_note, bus.o_octave, bus.o_x, bus.o_y} !== {n, o, xx, yy}) stable = 1'b0;
      len++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int c;
    reset = 1'b1; bus.i_valid = 1'b0; bus.i_note = '0; bus.i_octave = '0; bus.i_wipe = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.o_clear !== 1'b0) begin failures++; $display("FAIL reset_clear got=%0b want=0", bus.o_clear); end
    checks++; if (bus.o_ld_note !== 1'b0) begin failures++; $display("FAIL reset_ld got=%0b want=0", bus.o_ld_note); end
    checks++; if (bus.o_busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%0b want=1", bus.o_busy); end
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b want=1", bus.o_ready); end
    checks++; if ({bus.o_x, bus.o_y, bus.o_note, bus.o_octave} !== {8'd2, 7'd2, 4'd0, 2'd0}) begin failures++; $display("FAIL reset_glyph got x=%0d y=%0d n=%0d o=%0d want 2 2 0 0", bus.o_x, bus.o_y, bus.o_note, bus.o_octave); end
    reset = 1'b0;
    c = 0;
    while (!bus.o_clear && c < 25000) begin c++; @(negedge clk); end
    checks++; if (c !== 19600) begin failures++; $display("FAIL reset_clear_len got=%0d want=19600", c); end
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b want=0", bus.o_busy); end
    checks++; if ({bus.o_x, bus.o_y, bus.o_ld_note} !== {8'd2, 7'd2, 1'b0}) begin failures++; $display("FAIL idle_out got x=%0d y=%0d ld=%0b want 2 2 0", bus.o_x, bus.o_y, bus.o_ld_note); end
  endtask

  task automatic test_single;
    bit seen, st; int w, len; logic [3:0] n; logic [1:0] o; logic [7:0] xx; logic [6:0] yy;
    bus.i_valid = 1'b1; bus.i_note = 4'd3; bus.i_octave = 2'd1;
    checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%0b want=1", bus.o_ready); end
    @(negedge clk); bus.i_valid = 1'b0;
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL single_e0_busy got=%0b want=0", bus.o_busy); end
    @(negedge clk);
    checks++; if ({bus.o_note, bus.o_octave, bus.o_x, bus.o_y, bus.o_ld_note, bus.o_busy} !== {4'd3, 2'd1, 8'd2, 7'd2, 1'b0, 1'b1}) begin failures++; $display("FAIL single_load got n=%0d o=%0d x=%0d y=%0d ld=%0b busy=%0b want 3 1 2 2 0 1", bus.o_note, bus.o_octave, bus.o_x, bus.o_y, bus.o_ld_note, bus.o_busy); end
    wait_draw(10, seen, w, n, o, xx, yy, len, st);
    checks++; if (!seen || w !== 1) begin failures++; $display("FAIL single_ld_rise seen=%0b waited=%0d want 1 1", seen, w); end
    checks++; if (len !== 480) begin failures++; $display("FAIL single_ld_len got=%0d want=480", len); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL single_stable got=%0b want=1", st); end
    @(negedge clk);
    checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%0b want=0", bus.o_busy); end
  endtask

  task automatic test_back_to_back;
    bit seen, st; int w, len; logic [3:0] n; logic [1:0] o; logic [7:0] xx; logic [6:0] yy;
    bus.i_valid = 1'b1; bus.i_note = 4'd6; bus.i_octave = 2'd2;
    @(negedge clk); bus.i_valid = 1'b0;
    w = 0;
    while (!bus.o_ld_note && w < 10) begin @(negedge clk); w++; end
    checks++; if ({bus.o_ld_note, bus.o_note, bus.o_x, bus.o_y} !== {1'b1, 4'd6, 8'd42, 7'd2}) begin failures++; $display("FAIL next_slot got ld=%0b n=%0d x=%0d y=%0d want 1 6 42 2", bus.o_ld_note, bus.o_note, bus.o_x, bus.o_y); end
    for (int i = 0; i < 4; i++) begin
      bus.i_valid = 1'b1; bus.i_note = five_n[i]; bus.i_octave = five_o[i];
      checks++; if (bus.o_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready%0d got=%0b want=1", i, bus.o_ready); end
      @(negedge clk);
    end
    bus.i_note = five_n[4]; bus.i_octave = five_o[4];
    checks++; if (bus.o_ready !== 1'b0) begin failures++; $display("FAIL b2b_full got=%0b want=0", bus.o_ready); end
    w = 0;
    while (!bus.o_ready && w < 1000) begin @(negedge clk); w++; end
    checks++; if ({bus.o_ready, bus.o_busy, bus.o_ld_note, bus.o_note, bus.o_x} !== {1'b1, 1'b1, 1'b0, five_n[0], 8'd82}) begin failures++; $display("FAIL b2b_first_pop got rdy=%0b busy=%0b ld=%0b n=%0d x=%0d want 1 1 0 %0d 82", bus.o_ready, bus.o_busy, bus.o_ld_note, bus.o_note, bus.o_x, five_n[0]); end
    @(negedge clk); bus.i_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_draw(10, seen, w, n, o, xx, yy, len, st);
      checks++; if (!seen || {n, o, xx, yy} !== {five_n[i], five_o[i], 8'(ex_x(i + 2)), 7'(ex_y(i + 2))}) begin failures++; $display("FAIL b2b_draw%0d got n=%0d o=%0d x=%0d y=%0d want %0d %0d %0d %0d", i, n, o, xx, yy, five_n[i], five_o[i], ex_x(i + 2), ex_y(i + 2)); end
      checks++; if (len !== 480 || !st) begin failures++; $display("FAIL b2b_len%0d got=%0d stable=%0b want 480 1", i, len, st); end
    end
  endtask

  task automatic test_invalid;
    bit seen, st; int w, len; logic [3:0] n; logic [1:0] o; logic [7:0] xx; logic [6:0] yy;
    w = 0;
    while (bus.o_busy && w < 10) begin @(negedge clk); w++; end
    bus.i_valid = 1'b1; bus.i_note = 4'd0; bus.i_octave = 2'd1;
    @(negedge clk); bus.i_note = 4'd13;
    @(negedge clk); bus.i_note = 4'd5; bus.i_octave = 2'd0;
    @(negedge clk); bus.i_valid = 1'b0;
    wait_draw(10, seen, w, n, o, xx, yy, len, st);
    checks++; if (!seen || w !== 2) begin failures++; $display("FAIL invalid_latency seen=%0b waited=%0d want 1 2", seen, w); end
    checks++; if ({n, o, xx, yy} !== {4'd5, 2'd0, 8'd122, 7'd18}) begin failures++; $display("FAIL invalid_draw got n=%0d o=%0d x=%0d y=%0d want 5 0 122 18", n, o, xx, yy); end
    checks++; if (len !== 480) begin failures++; $display("FAIL invalid_len got=%0d want=480", len); end
  endtask

  task automatic test_grid_full;
    bit seen, st; int w, len, c; logic [3:0] n; logic [1:0] o; logic [7:0] xx; logic [6:0] yy;
    for (int k = 0; k < 20; k++) begin
      bus.i_valid = 1'b1; bus.i_note = 4'((k % 12) + 1); bus.i_octave = 2'(k % 4);
      @(negedge clk); bus.i_valid = 1'b0;
      wait_draw(10, seen, w, n, o, xx, yy, len, st);
      checks++; if (!seen || {xx, yy, n} !== {8'(ex_x(k + 8)), 7'(ex_y(k + 8)), 4'((k % 12) + 1)}) begin failures++; $display("FAIL fill_slot%0d got x=%0d y=%0d n=%0d want %0d %0d %0d", k + 8, xx, yy, n, ex_x(k + 8), ex_y(k + 8), (k % 12) + 1); end
      if (k == 19) begin
        checks++; if ({xx, yy} !== {8'd122, 7'd98}) begin failures++; $display("FAIL fill_last got x=%0d y=%0d want 122 98", xx, yy); end
      end
    end
    bus.i_valid = 1'b1; bus.i_note = 4'd10; bus.i_octave = 2'd1;
    @(negedge clk); bus.i_valid = 1'b0;
    c = 0;
    while (!bus.o_clear && c < 25000) begin c++; @(negedge clk); end
    checks++; if (c !== 19600) begin failures++; $display("FAIL full_clear_len got=%0d want=19600", c); end
    wait_draw(10, seen, w, n, o, xx, yy, len, st);
    checks++; if (!seen || {n, o, xx, yy} !== {4'd10, 2'd1, 8'd2, 7'd2}) begin failures++; $display("FAIL after_full got n=%0d o=%0d x=%0d y=%0d want 10 1 2 2", n, o, xx, yy); end
  endtask

  task automatic test_wipe;
    bit seen, st; int w, len, c; logic [3:0] n; logic [1:0] o; logic [7:0] xx; logic [6:0] yy;
    bus.i_valid = 1'b1; bus.i_note = 4'd9; bus.i_octave = 2'd2;
    @(negedge clk); bus.i_note = 4'd4; bus.i_octave = 2'd3;
    @(negedge clk); bus.i_valid = 1'b0;
    w = 0;
    while (!bus.o_ld_note && w < 10) begin @(negedge clk); w++; end
    checks++; if ({bus.o_ld_note, bus.o_note, bus.o_x, bus.o_y} !== {1'b1, 4'd9, 8'd42, 7'd2}) begin failures++; $display("FAIL wipe_draw got ld=%0b n=%0d x=%0d y=%0d want 1 9 42 2", bus.o_ld_note, bus.o_note, bus.o_x, bus.o_y); end
    len = 0;
    while (bus.o_ld_note && len < 2000) begin
      bus.i_wipe = (len == 100);
      len++;
      @(negedge clk);
    end
    bus.i_wipe = 1'b0;
    checks++; if (len !== 480) begin failures++; $display("FAIL wipe_draw_len got=%0d want=480", len); end
    @(negedge clk);
    checks++; if ({bus.o_busy, bus.o_clear} !== 2'b01) begin failures++; $display("FAIL wipe_idle got busy=%0b clear=%0b want 0 1", bus.o_busy, bus.o_clear); end
    @(negedge clk);
    c = 0;
    while (!bus.o_clear && c < 25000) begin c++; @(negedge clk); end
    checks++; if (c !== 19600) begin failures++; $display("FAIL wipe_clear_len got=%0d want=19600", c); end
    wait_draw(10, seen, w, n, o, xx, yy, len, st);
    checks++; if (!seen || {n, o, xx, yy} !== {4'd4, 2'd3, 8'd2, 7'd2}) begin failures++; $display("FAIL wipe_queued got n=%0d o=%0d x=%0d y=%0d want 4 3 2 2", n, o, xx, yy); end
    checks++; if (len !== 480) begin failures++; $display("FAIL wipe_queued_len got=%0d want=480", len); end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset;
    test_single;
    test_back_to_back;
    test_invalid;
    test_grid_full;
    test_wipe;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
